alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
// - Execute-stage datapath for the LEGv8 single-cycle CPU. Merges three functions:
//   - ALU-control decode of ALUOp and opcode[31:21].
//   - 64-bit ALU.
//   - Branch-offset shift-left-2 with branch-target add.
// - Outputs are registered: one-cycle latency into the PC/writeback muxes.
// PARAMETERS
// - XLEN   64  datapath width (operands, result, PC, immediate)
// PORTS
// - CLOCK       in   1     rising-edge clock
// - RESET_N     in   1     synchronous active-low reset
// - VALID_IN    in   1     operands/controls valid this cycle
// - ALU_OP      in   2     main-control ALUOp (00 ld/st, 01 CBZ/B, 10 R-type, 11 reserved)
// - OPCODE      in   11    INSTRUCTION[31:21]
// - OP_A        in   XLEN  ALU operand A (REG_DATA1)
// - OP_B        in   XLEN  ALU operand B (REG_DATA2 or sign-extended immediate, muxed upstream)
// - IMM         in   XLEN  sign-extended branch immediate (word offset)
// - PC_IN       in   XLEN  PC of the instruction
// - VALID_OUT   out  1     registered result valid
// - ALU_CTRL    out  4     registered 4-bit ALU operation code
// - RESULT      out  XLEN  registered ALU result
// - ZERO        out  1     registered (RESULT==0)
// - BR_TARGET   out  XLEN  registered PC_IN + (IMM<<2)
// BEHAVIOUR
// - Reset (RESET_N==0 at posedge): VALID_OUT, ALU_CTRL, RESULT, ZERO, BR_TARGET all 0.
//   Reset wins over VALID_IN.
// - Posedge with RESET_N==1 and VALID_IN==1: all outputs capture their combinational values;
//   VALID_OUT=1.
// - Posedge with VALID_IN==0: VALID_OUT=0; the data outputs hold their previous values.
// - ALU-control decode (combinational):
//   - ALU_OP 00 -> 0010 (ADD)
//   - ALU_OP 01 -> 0111 (pass B)
//   - ALU_OP 11 -> 0010 (ADD)
//   - ALU_OP 10, by OPCODE:
//     - 10001011000 ADD -> 0010
//     - 11001011000 SUB -> 0110
//     - 10001010000 AND -> 0000
//     - 10101010000 ORR -> 0001
//     - any other opcode -> 0010
// - ALU (combinational) by control code:
//   - 0000 A&B
//   - 0001 A|B
//   - 0010 A+B
//   - 0110 A-B
//   - 0111 B
//   - 1100 ~(A|B)
//   - any other code -> 0
// - Arithmetic rules:
//   - Add/sub are modulo 2^XLEN; carry and overflow are discarded; no flags other than ZERO.
//   - ZERO is derived from the full XLEN result.
// - Shift-left-2: {IMM[XLEN-3:0],2'b00}; the top two bits are dropped.
// - BR_TARGET = PC_IN + shifted IMM, modulo 2^XLEN. Negative IMM (two's complement) yields a
//   backward target.
// - BR_TARGET is computed every valid cycle regardless of ALU_OP; the branch decision stays
//   with the CPU (BRANCH & ZERO | UNCON_BRANCH).
// STRUCTURE
// - Shared package legv8_pkg holds:
//   - ALUOp constants: ALUOP_LDST=00, ALUOP_BR=01, ALUOP_RTYPE=10.
//   - ALU-control codes: ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR.
//   - R-type opcodes: OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR (11-bit).
// - One sub-module, alu64_core: purely combinational (A, B, ctrl -> result, zero). It is used
//   for the main ALU; the branch adder is a plain add.
// - Decode, shift and output registers sit in the top module.
// TESTING
// - R-type ADD: ALU_OP=10, OPCODE=10001011000, A=5, B=7, VALID_IN=1
//   -> next cycle RESULT=12, ZERO=0, ALU_CTRL=0010, VALID_OUT=1.
// - SUB to zero: OPCODE=11001011000, A=B=64'hDEAD_BEEF
//   -> RESULT=0, ZERO=1, ALU_CTRL=0110.
// - AND/ORR: A=64'hF0F0, B=64'h0FF0 -> AND RESULT=64'h00F0; ORR RESULT=64'hFFF0.
// - CBZ pass-B and branch target: ALU_OP=01, B=0, PC_IN=64'h40, IMM=-2 -> ZERO=1, BR_TARGET=64'h38.
// - Wrap and LDR address:
//   - ALU_OP=00, A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> RESULT=0, ZERO=1.
//   - IMM=64'h4000_0000_0000_0001, PC_IN=0 -> BR_TARGET=64'h4.
// - Reset/hold: RESET_N=0 with VALID_IN=1 -> all outputs 0. Then VALID_IN=0 after a valid op
//   -> VALID_OUT=0 and RESULT unchanged.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_pkg
// Description : Shared LEGv8 execute-stage constants, ALU codes and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_ctrl_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    // Unknown R-type opcodes and the reserved ALUOp both fall back to ADD.
    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                             input logic [10:0] opcode);
        alu_ctrl_e ctrl;
        ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_LDST: ctrl = ALU_ADD;
            ALUOP_BR:   ctrl = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: ctrl = ALU_ADD;
                    OPC_SUB: ctrl = ALU_SUB;
                    OPC_AND: ctrl = ALU_AND;
                    OPC_ORR: ctrl = ALU_ORR;
                    default: ctrl = ALU_ADD;
                endcase
            end
            default:    ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu64_core.sv
`default_nettype none
// ============================================================================
// Module      : alu64_core
// Description : Combinational XLEN-bit ALU with zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
module alu64_core
    import legv8_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_ctrl_e       i_ctrl,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    logic [XLEN-1:0] w_result;

    always_comb begin
        w_result = '0;
        case (i_ctrl)
            ALU_AND:   w_result = i_a & i_b;
            ALU_ORR:   w_result = i_a | i_b;
            ALU_ADD:   w_result = i_a + i_b;
            ALU_SUB:   w_result = i_a - i_b;
            ALU_PASSB: w_result = i_b;
            ALU_NOR:   w_result = ~(i_a | i_b);
            default:   w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : LEGv8 execute stage: ALU-control decode, ALU, branch target.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import legv8_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic            VALID_IN,
    input  logic [1:0]      ALU_OP,
    input  logic [10:0]     OPCODE,
    input  logic [XLEN-1:0] OP_A,
    input  logic [XLEN-1:0] OP_B,
    input  logic [XLEN-1:0] IMM,
    input  logic [XLEN-1:0] PC_IN,
    output logic            VALID_OUT,
    output logic [3:0]      ALU_CTRL,
    output logic [XLEN-1:0] RESULT,
    output logic            ZERO,
    output logic [XLEN-1:0] BR_TARGET
);

    alu_ctrl_e       w_ctrl;
    logic [XLEN-1:0] w_result;
    logic            w_zero;
    logic [XLEN-1:0] w_imm_shifted;
    logic [XLEN-1:0] w_br_target;

    logic            r_valid;
    logic [3:0]      r_ctrl;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic [XLEN-1:0] r_br_target;

    assign w_ctrl = alu_decode(ALU_OP, OPCODE);

    alu64_core #(
        .XLEN (XLEN)
    ) u_alu (
        .i_a      (OP_A),
        .i_b      (OP_B),
        .i_ctrl   (w_ctrl),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    // Word offset to byte offset; the two MSBs of IMM fall off the top.
    assign w_imm_shifted = IMM << 2;
    assign w_br_target   = PC_IN + w_imm_shifted;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_valid     <= 1'b0;
            r_ctrl      <= 4'b0000;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_valid <= VALID_IN;
            if (VALID_IN) begin
                r_ctrl      <= w_ctrl;
                r_result    <= w_result;
                r_zero      <= w_zero;
                r_br_target <= w_br_target;
            end
        end
    end

    assign VALID_OUT = r_valid;
    assign ALU_CTRL  = r_ctrl;
    assign RESULT    = r_result;
    assign ZERO      = r_zero;
    assign BR_TARGET = r_br_target;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed vector bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            valid_in;
    logic [1:0]      alu_op;
    logic [10:0]     opcode;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_in;
    logic            valid_out;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] br_target;

    int checks;
    int failures;

    typedef struct {
        string           name;
        logic [1:0]      alu_op;
        logic [10:0]     opcode;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [3:0]      exp_ctrl;
        logic [XLEN-1:0] exp_res;
        logic            exp_zero;
        logic [XLEN-1:0] exp_br;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    alu_exec_unit #(
        .XLEN (XLEN)
    ) dut (
        .CLOCK     (clk),
        .RESET_N   (rst_n),
        .VALID_IN  (valid_in),
        .ALU_OP    (alu_op),
        .OPCODE    (opcode),
        .OP_A      (op_a),
        .OP_B      (op_b),
        .IMM       (imm),
        .PC_IN     (pc_in),
        .VALID_OUT (valid_out),
        .ALU_CTRL  (alu_ctrl),
        .RESULT    (result),
        .ZERO      (zero),
        .BR_TARGET (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic v, input logic [1:0] op,
                         input logic [10:0] opc, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                         input logic [XLEN-1:0] pc);
        @(negedge clk);
        rst_n    = rn;
        valid_in = v;
        alu_op   = op;
        opcode   = opc;
        op_a     = a;
        op_b     = b;
        imm      = im;
        pc_in    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [3:0] c,
                             input logic [XLEN-1:0] r, input logic z,
                             input logic [XLEN-1:0] br);
        check({tag, ".valid_out"}, {63'd0, valid_out}, {63'd0, v});
        check({tag, ".alu_ctrl"},  {60'd0, alu_ctrl},  {60'd0, c});
        check({tag, ".result"},    result,             r);
        check({tag, ".zero"},      {63'd0, zero},      {63'd0, z});
        check({tag, ".br_target"}, br_target,          br);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{"add",       2'b10, 11'b10001011000, 64'd5, 64'd7, 64'd0, 64'd0,
                     4'b0010, 64'd12, 1'b0, 64'd0};
        vecs[1]  = '{"sub_zero",  2'b10, 11'b11001011000, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd1, 64'h100,
                     4'b0110, 64'd0, 1'b1, 64'h104};
        vecs[2]  = '{"and",       2'b10, 11'b10001010000, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0,
                     4'b0000, 64'h00F0, 1'b0, 64'd0};
        vecs[3]  = '{"orr",       2'b10, 11'b10101010000, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0,
                     4'b0001, 64'hFFF0, 1'b0, 64'd0};
        vecs[4]  = '{"cbz",       2'b01, 11'b10110100000, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h40,
                     4'b0111, 64'd0, 1'b1, 64'h38};
        vecs[5]  = '{"ldr_wrap",  2'b00, 11'b11111000010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                     64'h4000_0000_0000_0001, 64'd0, 4'b0010, 64'd0, 1'b1, 64'h4};
        vecs[6]  = '{"rsvd_add",  2'b11, 11'b11001011000, 64'd3, 64'd4, 64'd0, 64'd0,
                     4'b0010, 64'd7, 1'b0, 64'd0};
        vecs[7]  = '{"unk_opc",   2'b10, 11'b11111000010, 64'd10, 64'd20, 64'd0, 64'd0,
                     4'b0010, 64'd30, 1'b0, 64'd0};
        vecs[8]  = '{"sub_neg",   2'b10, 11'b11001011000, 64'd3, 64'd5, 64'd0, 64'd0,
                     4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'd0};
        vecs[9]  = '{"passb",     2'b01, 11'b00000000000, 64'd9, 64'h1234, 64'd3, 64'h100,
                     4'b0111, 64'h1234, 1'b0, 64'h10C};
        vecs[10] = '{"ldst_ign",  2'b00, 11'b11001011000, 64'd10, 64'd3, 64'd0, 64'd0,
                     4'b0010, 64'd13, 1'b0, 64'd0};
        vecs[11] = '{"and_msb",   2'b10, 11'b10001010000, 64'h8000_0000_0000_0000,
                     64'h8000_0000_0000_0001, 64'd0, 64'd0, 4'b0000, 64'h8000_0000_0000_0000,
                     1'b0, 64'd0};

        // Reset wins over a valid operation that would otherwise produce non-zero outputs.
        drive(1'b0, 1'b1, 2'b10, 11'b10001011000, 64'd5, 64'd7, 64'd1, 64'h40);
        check_all("reset", 1'b0, 4'b0000, 64'd0, 1'b0, 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, 1'b1, vecs[i].alu_op, vecs[i].opcode, vecs[i].a, vecs[i].b,
                  vecs[i].imm, vecs[i].pc);
            check_all(vecs[i].name, 1'b1, vecs[i].exp_ctrl, vecs[i].exp_res,
                      vecs[i].exp_zero, vecs[i].exp_br);
        end

        // Hold: a fresh valid op, then new inputs with VALID_IN low must not update data.
        drive(1'b1, 1'b1, 2'b10, 11'b10001011000, 64'd100, 64'd23, 64'd2, 64'h200);
        check_all("pre_hold", 1'b1, 4'b0010, 64'd123, 1'b0, 64'h208);
        drive(1'b1, 1'b0, 2'b10, 11'b11001011000, 64'd7, 64'd7, 64'd9, 64'h0);
        check_all("hold1", 1'b0, 4'b0010, 64'd123, 1'b0, 64'h208);
        drive(1'b1, 1'b0, 2'b01, 11'b10001010000, 64'd1, 64'd0, 64'd0, 64'h0);
        check_all("hold2", 1'b0, 4'b0010, 64'd123, 1'b0, 64'h208);

        // Valid again after idle, then mid-stream reset with VALID_IN high.
        drive(1'b1, 1'b1, 2'b10, 11'b10101010000, 64'h1, 64'h2, 64'd1, 64'h10);
        check_all("resume", 1'b1, 4'b0001, 64'h3, 1'b0, 64'h14);
        drive(1'b0, 1'b1, 2'b10, 11'b10101010000, 64'h1, 64'h2, 64'd1, 64'h10);
        check_all("reset2", 1'b0, 4'b0000, 64'd0, 1'b0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
